// File: rtl/ex_mem_pipe.sv
// rtl/ex_mem_pipe.sv - EX/MEM pipeline register chain with stall, flush and hazard match outputs
module ex_mem_pipe #(
  parameter int DW     = 32,
  parameter int RW     = 5,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              valide,
  input  logic              regwritee,
  input  logic              memtorege,
  input  logic              memwritee,
  input  logic [DW-1:0]     aluoute,
  input  logic [DW-1:0]     writedatae,
  input  logic [RW-1:0]     writerege,
  input  logic [RW-1:0]     srca,
  input  logic [RW-1:0]     srcb,
  output logic              validm,
  output logic              regwritem,
  output logic              memtoregm,
  output logic              memwritem,
  output logic [DW-1:0]     aluoutm,
  output logic [DW-1:0]     writedatam,
  output logic [RW-1:0]     writeregm,
  output logic [STAGES-1:0] matcha,
  output logic [STAGES-1:0] matchb,
  output logic [2:0]        inflight
);

  // Depth is limited so the 3-bit inflight count always fits.
  generate
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("ex_mem_pipe: STAGES must be in 1..4");
    end
  endgenerate

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_regwrite;
  logic [STAGES-1:0] r_memtoreg;
  logic [STAGES-1:0] r_memwrite;
  logic [DW-1:0]     r_aluout [STAGES];
  logic [DW-1:0]     r_wdata  [STAGES];
  logic [RW-1:0]     r_wreg   [STAGES];

  logic              w_srca_nz;
  logic              w_srcb_nz;

  // Stage registers: flush only kills valid bits, stall freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= '0;
      r_regwrite <= '0;
      r_memtoreg <= '0;
      r_memwrite <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_aluout[k] <= '0;
        r_wdata[k]  <= '0;
        r_wreg[k]   <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
    end else if (!stall) begin
      r_valid[0]    <= valide;
      r_regwrite[0] <= regwritee;
      r_memtoreg[0] <= memtorege;
      r_memwrite[0] <= memwritee;
      r_aluout[0]   <= aluoute;
      r_wdata[0]    <= writedatae;
      r_wreg[0]     <= writerege;
      for (int k = 1; k < STAGES; k++) begin
        r_valid[k]    <= r_valid[k-1];
        r_regwrite[k] <= r_regwrite[k-1];
        r_memtoreg[k] <= r_memtoreg[k-1];
        r_memwrite[k] <= r_memwrite[k-1];
        r_aluout[k]   <= r_aluout[k-1];
        r_wdata[k]    <= r_wdata[k-1];
        r_wreg[k]     <= r_wreg[k-1];
      end
    end
  end

  // Controls leaving the pipe are qualified by valid so bubbles never write.
  assign validm     = r_valid[STAGES-1];
  assign regwritem  = r_regwrite[STAGES-1] & r_valid[STAGES-1];
  assign memtoregm  = r_memtoreg[STAGES-1] & r_valid[STAGES-1];
  assign memwritem  = r_memwrite[STAGES-1] & r_valid[STAGES-1];
  assign aluoutm    = r_aluout[STAGES-1];
  assign writedatam = r_wdata[STAGES-1];
  assign writeregm  = r_wreg[STAGES-1];

  // Register 0 is hardwired zero, so it never counts as a hazard source.
  assign w_srca_nz = (srca != '0);
  assign w_srcb_nz = (srcb != '0);

  // Per-stage forwarding/hazard match against both source indices.
  always_comb begin
    matcha = '0;
    matchb = '0;
    for (int k = 0; k < STAGES; k++) begin
      matcha[k] = r_valid[k] & r_regwrite[k] & (r_wreg[k] == srca) & w_srca_nz;
      matchb[k] = r_valid[k] & r_regwrite[k] & (r_wreg[k] == srcb) & w_srcb_nz;
    end
  end

  // Occupancy is a direct popcount of the current valid bits.
  always_comb begin
    inflight = '0;
    for (int k = 0; k < STAGES; k++) begin
      inflight = inflight + {2'b00, r_valid[k]};
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb/tb_ex_mem_pipe.sv - directed self-checking bench for ex_mem_pipe at depths 1, 2 and 3
module tb_ex_mem_pipe;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        valide;
  logic        regwritee;
  logic        memtorege;
  logic        memwritee;
  logic [31:0] aluoute;
  logic [31:0] writedatae;
  logic [4:0]  writerege;
  logic [4:0]  srca;
  logic [4:0]  srcb;

  logic        s1_validm, s1_regwritem, s1_memtoregm, s1_memwritem;
  logic [31:0] s1_aluoutm, s1_writedatam;
  logic [4:0]  s1_writeregm;
  logic [0:0]  s1_matcha, s1_matchb;
  logic [2:0]  s1_inflight;

  logic        s2_validm, s2_regwritem, s2_memtoregm, s2_memwritem;
  logic [31:0] s2_aluoutm, s2_writedatam;
  logic [4:0]  s2_writeregm;
  logic [1:0]  s2_matcha, s2_matchb;
  logic [2:0]  s2_inflight;

  logic        s3_validm, s3_regwritem, s3_memtoregm, s3_memwritem;
  logic [31:0] s3_aluoutm, s3_writedatam;
  logic [4:0]  s3_writeregm;
  logic [2:0]  s3_matcha, s3_matchb;
  logic [2:0]  s3_inflight;

  int n_tests;
  int n_fail;

  ex_mem_pipe #(.DW(32), .RW(5), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valide(valide),
    .regwritee(regwritee), .memtorege(memtorege), .memwritee(memwritee),
    .aluoute(aluoute), .writedatae(writedatae), .writerege(writerege),
    .srca(srca), .srcb(srcb),
    .validm(s1_validm), .regwritem(s1_regwritem), .memtoregm(s1_memtoregm),
    .memwritem(s1_memwritem), .aluoutm(s1_aluoutm), .writedatam(s1_writedatam),
    .writeregm(s1_writeregm), .matcha(s1_matcha), .matchb(s1_matchb),
    .inflight(s1_inflight)
  );

  ex_mem_pipe #(.DW(32), .RW(5), .STAGES(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valide(valide),
    .regwritee(regwritee), .memtorege(memtorege), .memwritee(memwritee),
    .aluoute(aluoute), .writedatae(writedatae), .writerege(writerege),
    .srca(srca), .srcb(srcb),
    .validm(s2_validm), .regwritem(s2_regwritem), .memtoregm(s2_memtoregm),
    .memwritem(s2_memwritem), .aluoutm(s2_aluoutm), .writedatam(s2_writedatam),
    .writeregm(s2_writeregm), .matcha(s2_matcha), .matchb(s2_matchb),
    .inflight(s2_inflight)
  );

  ex_mem_pipe #(.DW(32), .RW(5), .STAGES(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valide(valide),
    .regwritee(regwritee), .memtorege(memtorege), .memwritee(memwritee),
    .aluoute(aluoute), .writedatae(writedatae), .writerege(writerege),
    .srca(srca), .srcb(srcb),
    .validm(s3_validm), .regwritem(s3_regwritem), .memtoregm(s3_memtoregm),
    .memwritem(s3_memwritem), .aluoutm(s3_aluoutm), .writedatam(s3_writedatam),
    .writeregm(s3_writeregm), .matcha(s3_matcha), .matchb(s3_matchb),
    .inflight(s3_inflight)
  );

  wire [79:0] s1_all = {s1_validm, s1_regwritem, s1_memtoregm, s1_memwritem, s1_aluoutm,
                        s1_writedatam, s1_writeregm, s1_matcha, s1_matchb, s1_inflight};
  wire [81:0] s2_all = {s2_validm, s2_regwritem, s2_memtoregm, s2_memwritem, s2_aluoutm,
                        s2_writedatam, s2_writeregm, s2_matcha, s2_matchb, s2_inflight};
  wire [83:0] s3_all = {s3_validm, s3_regwritem, s3_memtoregm, s3_memwritem, s3_aluoutm,
                        s3_writedatam, s3_writeregm, s3_matcha, s3_matchb, s3_inflight};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;
    valide     = 1'b0;
    regwritee  = 1'b0;
    memtorege  = 1'b0;
    memwritee  = 1'b0;
    aluoute    = '0;
    writedatae = '0;
    writerege  = '0;
    srca       = '0;
    srcb       = '0;

    // reset state
    repeat (2) tick();
    chk("rst_s1_all", s1_all, 0);
    chk("rst_s2_all", s2_all, 0);
    chk("rst_s3_all", s3_all, 0);
    rst_n = 1'b1;

    // single op through depth 1, then a bubble
    valide = 1'b1; regwritee = 1'b1; aluoute = 32'h1234; writerege = 5'd8; writedatae = 32'h55;
    tick();
    chk("s1_validm", s1_validm, 1);
    chk("s1_regwritem", s1_regwritem, 1);
    chk("s1_aluoutm", s1_aluoutm, 32'h1234);
    chk("s1_writeregm", s1_writeregm, 8);
    chk("s1_writedatam", s1_writedatam, 32'h55);
    chk("s1_memwritem", s1_memwritem, 0);
    chk("s1_inflight", s1_inflight, 1);
    chk("s3_validm_early", s3_validm, 0);
    chk("s3_inflight_1", s3_inflight, 1);
    valide = 1'b0;
    tick();
    chk("bubble_s1_validm", s1_validm, 0);
    chk("bubble_s1_regwritem", s1_regwritem, 0);
    chk("bubble_s1_inflight", s1_inflight, 0);
    chk("s2_validm_lat2", s2_validm, 1);
    chk("s2_aluoutm_lat2", s2_aluoutm, 32'h1234);
    chk("s3_inflight_bubble", s3_inflight, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_s3_inflight", s3_inflight, 0);

    // back-to-back A,B through depth 3
    valide = 1'b1; regwritee = 1'b0; writerege = 5'd0; aluoute = 32'hA;
    tick();
    chk("ab_e1_s3_inflight", s3_inflight, 1);
    aluoute = 32'hB;
    tick();
    chk("ab_e2_s3_inflight", s3_inflight, 2);
    chk("ab_e2_s3_validm", s3_validm, 0);
    chk("ab_e2_s2_aluoutm", s2_aluoutm, 32'hA);
    valide = 1'b0; aluoute = 32'h0;
    tick();
    chk("ab_e3_s3_aluoutm", s3_aluoutm, 32'hA);
    chk("ab_e3_s3_validm", s3_validm, 1);
    chk("ab_e3_s3_inflight", s3_inflight, 2);
    tick();
    chk("ab_e4_s3_aluoutm", s3_aluoutm, 32'hB);
    chk("ab_e4_s3_inflight", s3_inflight, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // stall hold with two ops in depth 2
    valide = 1'b1; memwritee = 1'b1; regwritee = 1'b0; aluoute = 32'hC;
    tick();
    memwritee = 1'b0; regwritee = 1'b1; aluoute = 32'hD; writerege = 5'd7;
    tick();
    chk("st_pre_s2_aluoutm", s2_aluoutm, 32'hC);
    chk("st_pre_s2_inflight", s2_inflight, 2);
    stall = 1'b1; aluoute = 32'hE; memwritee = 1'b1;
    repeat (3) tick();
    chk("st_s2_aluoutm", s2_aluoutm, 32'hC);
    chk("st_s2_memwritem", s2_memwritem, 1);
    chk("st_s2_regwritem", s2_regwritem, 0);
    chk("st_s2_inflight", s2_inflight, 2);
    chk("st_s1_aluoutm", s1_aluoutm, 32'hD);
    stall = 1'b0; valide = 1'b0; memwritee = 1'b0;
    tick();
    chk("rel1_s2_aluoutm", s2_aluoutm, 32'hD);
    chk("rel1_s2_regwritem", s2_regwritem, 1);
    chk("rel1_s2_memwritem", s2_memwritem, 0);
    chk("rel1_s2_writeregm", s2_writeregm, 7);
    chk("rel1_s2_inflight", s2_inflight, 1);
    tick();
    chk("rel2_s2_validm", s2_validm, 0);
    chk("rel2_s2_inflight", s2_inflight, 0);

    // flush wins over stall with a store in the last stage
    valide = 1'b1; memwritee = 1'b1; regwritee = 1'b0; aluoute = 32'hC;
    tick();
    memwritee = 1'b0; aluoute = 32'hF;
    tick();
    chk("fs_pre_s2_memwritem", s2_memwritem, 1);
    stall = 1'b1; flush = 1'b1;
    tick();
    chk("fs_s2_validm", s2_validm, 0);
    chk("fs_s2_memwritem", s2_memwritem, 0);
    chk("fs_s2_inflight", s2_inflight, 0);
    chk("fs_s3_inflight", s3_inflight, 0);
    stall = 1'b0; flush = 1'b0;

    // hazard match outputs
    valide = 1'b1; regwritee = 1'b0; writerege = 5'd5;
    tick();
    regwritee = 1'b1;
    tick();
    stall = 1'b1; srca = 5'd5; srcb = 5'd0;
    #1;
    chk("m_s2_matcha", s2_matcha, 2'b01);
    chk("m_s2_matchb", s2_matchb, 2'b00);
    chk("m_s3_matcha", s3_matcha, 3'b001);
    chk("m_s1_matcha", s1_matcha, 1'b1);
    srcb = 5'd5;
    #1;
    chk("m_s2_matchb5", s2_matchb, 2'b01);
    srcb = 5'd0;
    stall = 1'b0; writerege = 5'd0; srca = 5'd0; aluoute = 32'h99;
    tick();
    chk("m0_s2_matcha", s2_matcha, 2'b00);
    chk("r0_s1_writeregm", s1_writeregm, 0);
    chk("r0_s1_regwritem", s1_regwritem, 1);
    chk("r0_s1_aluoutm", s1_aluoutm, 32'h99);
    srca = 5'd5;
    #1;
    chk("m5_s2_matcha", s2_matcha, 2'b10);
    chk("m5_s3_matcha", s3_matcha, 3'b010);

    // asynchronous reset with a full pipe
    valide = 1'b1; regwritee = 1'b1; memtorege = 1'b1; aluoute = 32'h77; writerege = 5'd3; srca = 5'd3;
    tick();
    chk("full_s3_inflight", s3_inflight, 3);
    chk("full_s2_matcha", s2_matcha, 2'b01);
    #2;
    stall = 1'b1; flush = 1'b1; rst_n = 1'b0;
    #1;
    chk("arst_s1_all", s1_all, 0);
    chk("arst_s2_all", s2_all, 0);
    chk("arst_s3_all", s3_all, 0);
    tick();
    chk("arst_hold_s3_all", s3_all, 0);
    valide = 1'b0; regwritee = 1'b0; memtorege = 1'b0; aluoute = '0; writerege = '0;
    writedatae = '0; srca = '0; stall = 1'b0; flush = 1'b0; rst_n = 1'b1;
    tick();
    chk("post_s1_all", s1_all, 0);
    chk("post_s3_all", s3_all, 0);

    // first capture waits for stall to drop
    stall = 1'b1; valide = 1'b1; regwritee = 1'b1; aluoute = 32'h42;
    tick();
    chk("cap_stall_s1_validm", s1_validm, 0);
    chk("cap_stall_s1_inflight", s1_inflight, 0);
    stall = 1'b0;
    tick();
    chk("cap_s1_validm", s1_validm, 1);
    chk("cap_s1_aluoutm", s1_aluoutm, 32'h42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe.md
EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 SHALL provide parameter DW, default 32, ALU result and store-data width.
REQ-002 SHALL provide parameter RW, default 5, destination-register index width.
REQ-003 SHALL provide parameter STAGES, default 1, number of register stages (legal 1..4; other values fail elaboration).
REQ-004 SHALL provide port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL provide port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL provide ports stall  in  1  hold all stages; flush  in  1  invalidate all stages.
REQ-007 SHALL provide port valide  in  1  execute-stage instruction valid.
REQ-008 SHALL provide ports regwritee, memtorege, memwritee  in  1 each  execute-stage controls.
REQ-009 SHALL provide ports aluoute, writedatae  in  DW each; writerege  in  RW.
REQ-010 SHALL provide ports srca, srcb  in  RW each  source indices for hazard lookup.
REQ-011 SHALL provide ports validm, regwritem, memtoregm, memwritem  out  1 each  last-stage outputs.
REQ-012 SHALL provide ports aluoutm, writedatam  out  DW each; writeregm  out  RW.
REQ-013 SHALL provide ports matcha, matchb  out  STAGES  per-stage destination match (bit 0 = first stage).
REQ-014 SHALL provide port inflight  out  3  count of valid stages (0..STAGES).

Function
REQ-015 Stage 0 SHALL capture all execute-stage inputs on each edge where stall=0 and flush=0.
REQ-016 Stage k (k>0) SHALL capture stage k-1 contents on the same edges; latency input-to-output SHALL be exactly STAGES cycles with no stall.
REQ-017 stall=1, flush=0 SHALL hold every stage (data and valid) unchanged.
REQ-018 flush=1 SHALL clear every stage valid bit on the edge, regardless of stall (flush has priority); data fields MAY keep prior values.
REQ-019 regwritem and memwritem SHALL be the last-stage stored bits ANDed with validm; memtoregm likewise.
REQ-020 aluoutm, writedatam, writeregm SHALL drive last-stage stored values directly, ungated.
REQ-021 matcha[k] SHALL be 1 iff stage k valid, stage k regwrite=1, stage k writereg==srca, and srca!=0; matchb identical with srcb; combinational.
REQ-022 inflight SHALL equal population count of stage valid bits, registered-consistent (reflects current stage state, no extra delay).
REQ-023 valide=0 with stall=0 SHALL insert a bubble: stage 0 valid cleared, controls captured but gated per REQ-019.
REQ-024 Writing register 0 SHALL pass through unchanged; only match outputs exclude index 0.
REQ-025 Block SHALL use non-blocking assignment semantics: each stage samples the pre-edge value of its predecessor.

Reset
REQ-026 rst_n=0 SHALL immediately, independent of clk, clear all stage valid, control, data, and index fields to 0.
REQ-027 During reset all outputs SHALL be 0: validm, regwritem, memtoregm, memwritem, aluoutm, writedatam, writeregm, matcha, matchb, inflight.
REQ-028 Reset asserted mid-stall or mid-flush SHALL override both; first capture SHALL occur on the first rising edge with rst_n=1 and stall=0.

Verification
REQ-029 STAGES=1: valide=1, regwritee=1, aluoute=0x0000_1234, writerege=8 -> one edge later validm=1, regwritem=1, aluoutm=0x1234, writeregm=8.
REQ-030 STAGES=3: issue A (aluout 0xA) then B (0xB) back-to-back -> aluoutm=0xA at edge 3, 0xB at edge 4, inflight=2 after edge 2.
REQ-031 STAGES=2, two valid ops in flight, stall=1 for 3 edges -> outputs and inflight=2 unchanged; on release, pipeline advances one stage per edge.
REQ-032 STAGES=2, flush=1 and stall=1 same edge with memwrite op in stage 1 -> after edge validm=0, memwritem=0, inflight=0.
REQ-033 STAGES=2, stage 0 writereg=5 regwrite=1, stage 1 writereg=5 regwrite=0, srca=5, srcb=0 -> matcha=2'b01, matchb=2'b00; stage 0 writereg=0 with srca=0 -> matcha[0]=0.
REQ-034 Assert rst_n=0 between clock edges with full pipeline -> all outputs 0 before next edge; deassert, valide=0 -> outputs remain 0.
